// File: rtl/fifo_rw_ctrl_pkg.sv
// Shared definitions for the FIFO read/write bring-up sequencer.
package fifo_rw_ctrl_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_UW = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PURGE = 3'd1,
    ST_FILL  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FLUSH = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/fifo_rw_ctrl_checker.sv
// Read-back checker: delays the drain read strobe to line up with the FIFO
// output register, compares against a counting expected value and counts
// every checked word.
module fifo_rw_ctrl_checker
  import fifo_rw_ctrl_pkg::*;
#(
  parameter int             DW   = DEF_DW,
  parameter int             UW   = DEF_UW,
  parameter logic [DW-1:0]  SEED = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          rd_issue,
  input  logic [DW-1:0] fifo_q,
  output logic          mismatch,
  output logic [UW:0]   rd_count
);

  logic          rd_valid_d, rd_valid_q;
  logic [DW-1:0] exp_d, exp_q;
  logic [UW:0]   rd_count_d, rd_count_q;

  // Advance the expected pattern and the checked-word count on each valid word.
  always_comb begin
    rd_valid_d = rd_issue;
    exp_d      = exp_q;
    rd_count_d = rd_count_q;
    if (clear) begin
      exp_d      = SEED;
      rd_count_d = '0;
    end else if (rd_valid_q) begin
      exp_d      = exp_q + DW'(1);
      rd_count_d = rd_count_q + (UW+1)'(1);
    end
  end

  assign mismatch = rd_valid_q && (fifo_q != exp_q);
  assign rd_count = rd_count_q;

  // Checker state registers; FIFO read data is one cycle behind the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      exp_q      <= SEED;
      rd_count_q <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      exp_q      <= exp_d;
      rd_count_q <= rd_count_d;
    end
  end

endmodule

// File: rtl/fifo_rw_ctrl.sv
// FIFO bring-up sequencer: purge leftovers, fill with a counting pattern,
// hold, drain and verify the read-back data, then pulse done.
module fifo_rw_ctrl
  import fifo_rw_ctrl_pkg::*;
#(
  parameter int            DW       = DEF_DW,
  parameter int            UW       = DEF_UW,
  parameter int            BURST    = 256,
  parameter int            WAIT_CYC = 16,
  parameter logic [DW-1:0] SEED     = 8'h00
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  input  logic [UW-1:0] fifo_usedw,
  input  logic [DW-1:0] fifo_q,
  output logic          wr_req,
  output logic [DW-1:0] wr_data,
  output logic          rd_req,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [UW:0]   wr_count,
  output logic [UW:0]   rd_count,
  output logic [UW-1:0] level
);

  localparam logic [UW:0]   BURST_W   = (UW+1)'(BURST);
  localparam int            HW        = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(WAIT_CYC - 1);

  state_t        state_d, state_q;
  logic [DW-1:0] wr_data_d, wr_data_q;
  logic [UW:0]   wr_count_d, wr_count_q;
  logic [HW-1:0] hold_d, hold_q;
  logic          err_d, err_q;
  logic          done_d, done_q;
  logic [UW-1:0] level_d, level_q;

  logic          clear;
  logic          rd_issue;
  logic          mismatch;
  logic [UW:0]   chk_rd_count;

  fifo_rw_ctrl_checker #(
    .DW   (DW),
    .UW   (UW),
    .SEED (SEED)
  ) u_checker (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .clear    (clear),
    .rd_issue (rd_issue),
    .fifo_q   (fifo_q),
    .mismatch (mismatch),
    .rd_count (chk_rd_count)
  );

  // Sequencer next-state and request logic; only drain reads are checked.
  always_comb begin
    state_d    = state_q;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q;
    hold_d     = hold_q;
    err_d      = err_q | mismatch;
    done_d     = 1'b0;
    level_d    = fifo_usedw;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    rd_issue   = 1'b0;
    clear      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear      = 1'b1;
          err_d      = 1'b0;
          wr_count_d = '0;
          wr_data_d  = SEED;
          hold_d     = '0;
          state_d    = fifo_empty ? ST_FILL : ST_PURGE;
        end
      end
      ST_PURGE: begin
        rd_req = !fifo_empty;
        if (fifo_empty) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        wr_req = (wr_count_q != BURST_W) && !fifo_full;
        if (wr_req) begin
          wr_data_d  = wr_data_q + DW'(1);
          wr_count_d = wr_count_q + (UW+1)'(1);
        end
        if (fifo_full || (wr_count_d == BURST_W)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_DRAIN: begin
        rd_req   = !fifo_empty;
        rd_issue = !fifo_empty;
        if (fifo_empty) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // The final compare has landed by now, so fold in the count check
        // here so err is already valid while done is high.
        err_d   = err_q | mismatch | (chk_rd_count != wr_count_q);
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; FIFO contents are not touched by reset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      wr_data_q  <= SEED;
      wr_count_q <= '0;
      hold_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      done_q     <= done_d;
      level_q    <= level_d;
    end
  end

  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;
  assign rd_count = chk_rd_count;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign level    = level_q;

endmodule

// File: tb/tb_fifo_rw_ctrl.sv
// Testbench for fifo_rw_ctrl: two sequencer instances (full 256-word burst
// and a short wrapping burst) each talking to a behavioural 8x256 FIFO.
module tb_fifo_rw_ctrl;

  localparam int LOGN = 1024;

  typedef struct {
    int inst;
    int add;
    int corrupt;
    bit extra;
    int exp_wr;
    int exp_rd;
    bit exp_err;
    int exp_lat;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       rst [2];
  logic       start [2];
  logic       f_full [2];
  logic       f_empty [2];
  logic [7:0] f_usedw [2];
  logic [7:0] f_q [2];
  logic       wr_req [2];
  logic       rd_req [2];
  logic       busy [2];
  logic       done [2];
  logic       err [2];
  logic [7:0] wr_data [2];
  logic [7:0] level [2];
  logic [8:0] wr_count [2];
  logic [8:0] rd_count [2];

  logic       tb_wr [2];
  logic [7:0] tb_data [2];
  int         corrupt_at [2];

  logic [7:0] mem [2][256];
  logic [7:0] wp [2] = '{8'd0, 8'd0};
  logic [7:0] rp [2] = '{8'd0, 8'd0};
  int         cnt [2] = '{0, 0};
  int         rd_total [2] = '{0, 0};

  logic [7:0] wlog [2][LOGN];
  int         widx [2] = '{0, 0};
  int         done_count [2] = '{0, 0};

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  fifo_rw_ctrl #(
    .DW(8), .UW(8), .BURST(256), .WAIT_CYC(16), .SEED(8'h00)
  ) u_big (
    .sys_clk(sys_clk), .sys_rst(rst[0]), .start(start[0]),
    .fifo_full(f_full[0]), .fifo_empty(f_empty[0]), .fifo_usedw(f_usedw[0]), .fifo_q(f_q[0]),
    .wr_req(wr_req[0]), .wr_data(wr_data[0]), .rd_req(rd_req[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]),
    .wr_count(wr_count[0]), .rd_count(rd_count[0]), .level(level[0])
  );

  fifo_rw_ctrl #(
    .DW(8), .UW(8), .BURST(10), .WAIT_CYC(4), .SEED(8'hFC)
  ) u_small (
    .sys_clk(sys_clk), .sys_rst(rst[1]), .start(start[1]),
    .fifo_full(f_full[1]), .fifo_empty(f_empty[1]), .fifo_usedw(f_usedw[1]), .fifo_q(f_q[1]),
    .wr_req(wr_req[1]), .wr_data(wr_data[1]), .rd_req(rd_req[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]),
    .wr_count(wr_count[1]), .rd_count(rd_count[1]), .level(level[1])
  );

  // FIFO status flags follow the occupancy; usedw wraps to 0 when full.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      f_full[i]  = (cnt[i] == 256);
      f_empty[i] = (cnt[i] == 0);
      f_usedw[i] = 8'(cnt[i]);
    end
  end

  // Behavioural single-clock FIFO with registered read data and an optional
  // one-shot bit-0 corruption on a chosen absolute read number.
  always @(posedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if ((wr_req[i] || tb_wr[i]) && cnt[i] != 256) begin
        mem[i][wp[i]] <= tb_wr[i] ? tb_data[i] : wr_data[i];
        wp[i] <= wp[i] + 8'd1;
      end
      if (rd_req[i] && cnt[i] != 0) begin
        f_q[i] <= mem[i][rp[i]] ^ (((rd_total[i] + 1) == corrupt_at[i]) ? 8'h01 : 8'h00);
        rp[i] <= rp[i] + 8'd1;
        rd_total[i] <= rd_total[i] + 1;
      end
      cnt[i] <= cnt[i] + int'((wr_req[i] || tb_wr[i]) && cnt[i] != 256) - int'(rd_req[i] && cnt[i] != 0);
    end
  end

  // Log every word the sequencer writes and every done pulse it emits.
  always @(posedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_req[i] && !f_full[i]) begin
        wlog[i][widx[i] % LOGN] <= wr_data[i];
        widx[i] <= widx[i] + 1;
      end
      if (done[i]) begin
        done_count[i] <= done_count[i] + 1;
      end
    end
  end

  function automatic int burst_of(input int i);
    return (i == 0) ? 256 : 10;
  endfunction

  function automatic int wait_of(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int seed_of(input int i);
    return (i == 0) ? 8'h00 : 8'hFC;
  endfunction

  // Run length from start to the done pulse: fill, hold, drain, plus the
  // fixed overhead, plus the purge pass when leftovers are present.
  function automatic int model_latency(input int i, input int leftovers);
    return 2 * burst_of(i) + wait_of(i) + 3 + ((leftovers > 0) ? leftovers + 1 : 0);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i);
    start[i] = 1'b1;
    @(negedge sys_clk);
    start[i] = 1'b0;
  endtask

  task automatic check_reset(input int i, input string tag);
    checkOutput({tag, " busy"}, int'(busy[i]), 0);
    checkOutput({tag, " wr_req"}, int'(wr_req[i]), 0);
    checkOutput({tag, " rd_req"}, int'(rd_req[i]), 0);
    checkOutput({tag, " done"}, int'(done[i]), 0);
    checkOutput({tag, " err"}, int'(err[i]), 0);
    checkOutput({tag, " wr_count"}, int'(wr_count[i]), 0);
    checkOutput({tag, " rd_count"}, int'(rd_count[i]), 0);
    checkOutput({tag, " level"}, int'(level[i]), 0);
    checkOutput({tag, " wr_data"}, int'(wr_data[i]), seed_of(i));
  endtask

  // One complete run: optional junk preload, start, mid-run probes, done.
  task automatic run_case(input int i, input int add, input int residue, input int corrupt, input bit extra,
                          input int exp_wr, input int exp_rd, input bit exp_err, input int exp_lat,
                          input string tag);
    int burst, lead, n, w0, p0, d0, nw, bad;
    burst = burst_of(i);
    if (add > 0) begin
      tb_wr[i] = 1'b1;
      for (int k = 0; k < add; k++) begin
        tb_data[i] = 8'($urandom);
        @(negedge sys_clk);
      end
      tb_wr[i] = 1'b0;
    end
    lead = (residue + add > 0) ? residue + add + 1 : 0;
    w0 = widx[i];
    p0 = rd_total[i];
    d0 = done_count[i];
    corrupt_at[i] = (corrupt > 0) ? p0 + residue + add + corrupt : 0;
    applyStimulus(i);
    n = 1;
    checkOutput({tag, " busy after start"}, int'(busy[i]), 1);
    checkOutput({tag, " err cleared by start"}, int'(err[i]), 0);
    checkOutput({tag, " wr_count cleared"}, int'(wr_count[i]), 0);
    checkOutput({tag, " rd_count cleared"}, int'(rd_count[i]), 0);
    if (lead == 0) begin
      checkOutput({tag, " first wr_req"}, int'(wr_req[i]), 1);
      checkOutput({tag, " first wr_data"}, int'(wr_data[i]), seed_of(i));
    end else begin
      checkOutput({tag, " purge rd_req"}, int'(rd_req[i]), 1);
      checkOutput({tag, " no write while purging"}, int'(wr_req[i]), 0);
    end
    repeat (lead + burst + 1) @(negedge sys_clk);
    n += lead + burst + 1;
    checkOutput({tag, " level in hold"}, int'(level[i]), burst % 256);
    checkOutput({tag, " wr_count in hold"}, int'(wr_count[i]), exp_wr);
    checkOutput({tag, " hold wr_req"}, int'(wr_req[i]), 0);
    checkOutput({tag, " hold rd_req"}, int'(rd_req[i]), 0);
    if (extra) begin
      repeat (wait_of(i) + 1) @(negedge sys_clk);
      n += wait_of(i) + 1;
      applyStimulus(i);
      n++;
    end
    while (done[i] !== 1'b1 && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput({tag, " done seen"}, int'(done[i]), 1);
    checkOutput({tag, " done latency"}, n, exp_lat);
    checkOutput({tag, " wr_count at done"}, int'(wr_count[i]), exp_wr);
    checkOutput({tag, " rd_count at done"}, int'(rd_count[i]), exp_rd);
    checkOutput({tag, " err at done"}, int'(err[i]), int'(exp_err));
    repeat (2) @(negedge sys_clk);
    checkOutput({tag, " done is one cycle"}, int'(done[i]), 0);
    checkOutput({tag, " idle after run"}, int'(busy[i]), 0);
    checkOutput({tag, " done pulses"}, done_count[i] - d0, 1);
    checkOutput({tag, " err held in idle"}, int'(err[i]), int'(exp_err));
    nw = widx[i] - w0;
    checkOutput({tag, " words written"}, nw, exp_wr);
    bad = 0;
    for (int k = 0; k < nw && k < LOGN; k++) begin
      if (wlog[i][(w0 + k) % LOGN] !== 8'(seed_of(i) + k)) bad++;
    end
    checkOutput({tag, " write pattern errors"}, bad, 0);
    checkOutput({tag, " total reads"}, rd_total[i] - p0, residue + add + exp_rd);
  endtask

  // Main sequence: reset state, scenario table, reset corner cases, random runs.
  initial begin
    vec_t vecs [7];
    int ri, radd, rcor, burst;
    bit rext;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      start[i] = 1'b0;
      tb_wr[i] = 1'b0;
      tb_data[i] = 8'h00;
      corrupt_at[i] = 0;
    end

    vecs[0] = '{0, 0, 0, 1'b0, 256, 256, 1'b0, 531};
    vecs[1] = '{1, 0, 0, 1'b0, 10, 10, 1'b0, 27};
    vecs[2] = '{1, 5, 0, 1'b0, 10, 10, 1'b0, 33};
    vecs[3] = '{1, 0, 3, 1'b0, 10, 10, 1'b1, 27};
    vecs[4] = '{1, 0, 0, 1'b0, 10, 10, 1'b0, 27};
    vecs[5] = '{0, 0, 0, 1'b1, 256, 256, 1'b0, 531};
    vecs[6] = '{1, 2, 7, 1'b1, 10, 10, 1'b1, 30};

    repeat (2) @(negedge sys_clk);
    check_reset(0, "reset big");
    check_reset(1, "reset small");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge sys_clk);

    for (int v = 0; v < 7; v++) begin
      run_case(vecs[v].inst, vecs[v].add, 0, vecs[v].corrupt, vecs[v].extra,
               vecs[v].exp_wr, vecs[v].exp_rd, vecs[v].exp_err, vecs[v].exp_lat,
               $sformatf("vec%0d", v));
    end

    // Reset in the middle of FILL leaves residue that the next run purges.
    applyStimulus(0);
    repeat (7) @(negedge sys_clk);
    checkOutput("mid-fill wr_count", int'(wr_count[0]), 7);
    rst[0] = 1'b1;
    #1;
    check_reset(0, "mid-fill reset");
    @(negedge sys_clk);
    rst[0] = 1'b0;
    @(negedge sys_clk);
    checkOutput("residue after reset", cnt[0], 7);
    run_case(0, 0, 7, 0, 1'b0, 256, 256, 1'b0, 539, "after reset");

    // Start presented together with reset is lost to the reset.
    rst[1] = 1'b1;
    start[1] = 1'b1;
    @(negedge sys_clk);
    start[1] = 1'b0;
    rst[1] = 1'b0;
    @(negedge sys_clk);
    checkOutput("start under reset busy", int'(busy[1]), 0);
    checkOutput("start under reset wr_req", int'(wr_req[1]), 0);

    // Randomised runs checked against the run-level model.
    for (int r = 0; r < 6; r++) begin
      ri = int'($urandom_range(0, 1));
      burst = burst_of(ri);
      radd = int'($urandom_range(0, 12));
      rcor = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, burst)) : 0;
      rext = 1'($urandom_range(0, 1));
      run_case(ri, radd, 0, rcor, rext, burst, burst, (rcor != 0), model_latency(ri, radd),
               $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
